// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and constants for the UART transmitter.
// Build option UART_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int CNT_WIDTH  = 4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/parity_calc.sv
// parity_calc: even/odd parity over one data byte.
module parity_calc
    import uart_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  typ,
    output logic                  parity
);

    assign parity = (typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART frame controller (start, 8 data bits from an external serializer,
// optional parity, stop). Build option UART_PARITY_EN adds par_en/par_typ and the PARITY state.
module uart_tx_fsm
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    input  logic                  ser_data,
    input  logic                  ser_done,
`ifdef UART_PARITY_EN
    input  logic                  par_en,
    input  logic                  par_typ,
`endif
    output logic                  enable,
    output logic                  busy,
    output logic                  tx_out
);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] byte_q;
    logic                  par_bit;
    logic                  data_last;
`ifdef UART_PARITY_EN
    logic                  par_en_q;
    logic                  typ_q;
`else
    logic                  unused_par;
`endif

`ifdef UART_PARITY_EN
    parity_calc u_parity (.data(byte_q), .typ(typ_q), .parity(par_bit));
`else
    parity_calc u_parity (.data(byte_q), .typ(PAR_EVEN), .parity(par_bit));
    assign unused_par = par_bit;
`endif

    // DATA ends on the serializer's flag or after the 8th bit cycle, whichever comes first
    assign data_last = ser_done || (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Frame settings are latched on acceptance so mid-frame input changes have no effect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_q   <= '0;
`ifdef UART_PARITY_EN
            par_en_q <= 1'b0;
            typ_q    <= PAR_EVEN;
`endif
        end else if (state == ST_IDLE && valid) begin
            byte_q   <= data_in;
`ifdef UART_PARITY_EN
            par_en_q <= par_en;
            typ_q    <= par_typ;
`endif
        end
    end

    // Bit counter runs only in DATA and restarts from zero for every frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= (state == ST_DATA) ? cnt + 1'b1 : '0;
    end

    // Next-state logic; busy states ignore valid, so nothing is queued
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = valid ? ST_START : ST_IDLE;
            ST_START:  state_nxt = ST_DATA;
`ifdef UART_PARITY_EN
            ST_DATA:   state_nxt = data_last ? (par_en_q ? ST_PARITY : ST_STOP) : ST_DATA;
            ST_PARITY: state_nxt = ST_STOP;
`else
            ST_DATA:   state_nxt = data_last ? ST_STOP : ST_DATA;
`endif
            ST_STOP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only; tx_out also passes the serial bit or parity bit
    always_comb begin
        busy   = (state != ST_IDLE);
        enable = (state == ST_DATA);
        tx_out = 1'b1;
        case (state)
            ST_START:  tx_out = 1'b0;
            ST_DATA:   tx_out = ser_data;
`ifdef UART_PARITY_EN
            ST_PARITY: tx_out = par_bit;
`endif
            default:   tx_out = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk is the only clock, and rst is the reset.
REQ-002 Port: clk  in  1  system clock; every state element updates on the rising edge.
REQ-003 Port: rst  in  1  asynchronous active-low reset.
REQ-004 Port: data_in  in  8  parallel byte; the serializer receives the same byte.
REQ-005 Port: valid  in  1  byte-request strobe; shared with the serializer.
REQ-006 Port: ser_data  in  1  current serial bit from the serializer.
REQ-007 Port: ser_done  in  1  serializer flag; high in the cycle the 8th data bit is on ser_data.
REQ-008 Port: par_en  in  1  parity enable; present only with UART_PARITY_EN.
REQ-009 Port: par_typ  in  1  parity type, 0=even, 1=odd; present only with UART_PARITY_EN.
REQ-010 Port: enable  out  1  serializer shift enable.
REQ-011 Port: busy  out  1  frame in progress; feeds the serializer busy input and the upstream source.
REQ-012 Port: tx_out  out  1  UART line; idles high.

Function
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY and STOP in a single state register.
REQ-014 IDLE: tx_out=1, busy=0, enable=0; on valid=1 SHALL capture data_in (plus par_en and par_typ) and go to START next cycle.
REQ-015 START: tx_out=0, busy=1, enable=0; SHALL last exactly 1 cycle, then go to DATA.
REQ-016 DATA: tx_out=ser_data, busy=1, enable=1; a 4-bit bit counter SHALL increment each cycle.
REQ-017 DATA SHALL exit on ser_done=1 or when the counter reaches 8, whichever comes first; early ser_done SHALL end DATA early.
REQ-018 On DATA exit, the next state SHALL be PARITY if the captured par_en=1, otherwise STOP.
REQ-019 PARITY: tx_out=parity bit, busy=1, enable=0; SHALL last 1 cycle, then go to STOP.
REQ-020 Parity bit SHALL be even = XOR of the captured byte; odd = its inverse.
REQ-021 STOP: tx_out=1, busy=1, enable=0; SHALL last 1 cycle, then return to IDLE.
REQ-022 Frame length SHALL be 11 cycles with parity and 10 cycles without.
REQ-023 A valid pulse while busy=1 SHALL be ignored, including during STOP; no queueing.
REQ-024 valid=1 held through the IDLE return SHALL start a new frame; a gap of at least 1 IDLE cycle SHALL separate frames.
REQ-025 Changing par_en, par_typ or data_in mid-frame SHALL NOT affect the current frame.
REQ-026 Outputs SHALL be decoded from the state (tx_out additionally from ser_data and the parity register), with no combinational path from valid.

Reset
REQ-027 When rst=0, SHALL asynchronously force IDLE: tx_out=1, busy=0, enable=0, counter=0, captured byte and parity cleared.
REQ-028 Reset mid-frame SHALL abort the frame; after release, the block SHALL wait in IDLE for a new valid.

Configuration
REQ-029 Macro UART_PARITY_EN defined: par_en and par_typ ports, the PARITY state and parity logic SHALL be present.
REQ-030 Macro undefined: those ports and the PARITY state SHALL be absent, and DATA SHALL always exit to STOP.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state encodings, DATA_WIDTH=8, and PAR_EVEN=0 / PAR_ODD=1.
REQ-032 Parity SHALL be computed in a sub-module parity_calc (8-bit data and type in, 1-bit parity out).

Verification
REQ-033 Reset held, then released, with valid=0 -> tx_out=1, busy=0, enable=0 indefinitely.
REQ-034 data_in=0x4B, par_en=1, par_typ=0, 1-cycle valid -> tx_out: 0, 1,1,0,1,0,0,1,0 (LSB first), then parity 0, then 1; busy high 11 cycles.
REQ-035 Same byte with par_typ=1 -> parity bit 1; with par_en=0 -> 10-cycle frame with no parity bit.
REQ-036 Second valid pulse at the 4th DATA cycle -> ignored; a single frame only.
REQ-037 rst=0 at the 5th DATA cycle -> tx_out=1, busy=0, enable=0 in the same cycle; next valid -> clean full frame.
REQ-038 ser_done forced high at the 3rd DATA cycle -> DATA exits after 3 cycles; ser_done held 0 -> DATA exits after 8 cycles.
